// File: rtl/image_draw_ctl_if.sv
`default_nettype none
// ============================================================================
// image_draw_ctl_if : pixel timing, background colour, sprite position and
//                     ROM bus bundle for image_draw_ctl
// Revision: 1.0
// ============================================================================
interface image_draw_ctl_if;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output rgb_in, xpos, ypos, rom_rgb,
    input  rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    input  hblnk_out, vblnk_out, rgb_out
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  rgb_in, xpos, ypos, rom_rgb,
    output rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    output hblnk_out, vblnk_out, rgb_out
  );
endinterface
`default_nettype wire

// File: rtl/image_draw_ctl.sv
`default_nettype none
// ============================================================================
// image_draw_ctl : overlays a 64x64 ROM sprite with colour-key transparency
//                  on a video stream, two-clock pipeline
// Revision: 1.0
// ============================================================================
module image_draw_ctl #(
  parameter logic [11:0] XPOS_RST = 12'd0,
  parameter logic [11:0] YPOS_RST = 12'd0,
  parameter logic [11:0] KEY_RGB  = 12'hF0F
) (
  input  logic             clk,
  input  logic             rst_n,
  image_draw_ctl_if.slave  bus
);

  localparam logic [12:0] C_SPRITE_SIZE = 13'd64;

  logic [11:0] r_xpos_l;
  logic [11:0] r_ypos_l;
  logic        r_vblnk_prev;

  logic [10:0] r_hcount1, r_vcount1;
  logic        r_hsync1, r_vsync1, r_hblnk1, r_vblnk1;
  logic [11:0] r_rgb1;
  logic        r_win1;
  logic [11:0] r_rom_addr;

  logic [10:0] r_hcount2, r_vcount2;
  logic        r_hsync2, r_vsync2, r_hblnk2, r_vblnk2;
  logic [11:0] r_rgb2;

  logic [12:0] w_h13, w_v13, w_x13, w_y13;
  logic        w_in_win;
  logic [5:0]  w_col;
  logic [5:0]  w_row;
  logic [11:0] w_pix;

  // 13-bit compare keeps xpos_l+64 from wrapping near the top of the range
  assign w_h13    = {2'b00, bus.hcount_in};
  assign w_v13    = {2'b00, bus.vcount_in};
  assign w_x13    = {1'b0, r_xpos_l};
  assign w_y13    = {1'b0, r_ypos_l};
  assign w_in_win = (w_h13 >= w_x13) && (w_h13 < w_x13 + C_SPRITE_SIZE) &&
                    (w_v13 >= w_y13) && (w_v13 < w_y13 + C_SPRITE_SIZE);

  // Low six bits of the offset depend only on the low six bits of the operands
  assign w_col = bus.hcount_in[5:0] - r_xpos_l[5:0];
  assign w_row = bus.vcount_in[5:0] - r_ypos_l[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xpos_l     <= XPOS_RST;
      r_ypos_l     <= YPOS_RST;
      r_vblnk_prev <= 1'b0;
    end else begin
      r_vblnk_prev <= bus.vblnk_in;
      if (bus.vblnk_in && !r_vblnk_prev) begin
        r_xpos_l <= bus.xpos;
        r_ypos_l <= bus.ypos;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount1  <= '0;
      r_vcount1  <= '0;
      r_hsync1   <= 1'b0;
      r_vsync1   <= 1'b0;
      r_hblnk1   <= 1'b0;
      r_vblnk1   <= 1'b0;
      r_rgb1     <= '0;
      r_win1     <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_hcount1  <= bus.hcount_in;
      r_vcount1  <= bus.vcount_in;
      r_hsync1   <= bus.hsync_in;
      r_vsync1   <= bus.vsync_in;
      r_hblnk1   <= bus.hblnk_in;
      r_vblnk1   <= bus.vblnk_in;
      r_rgb1     <= bus.rgb_in;
      r_win1     <= w_in_win;
      r_rom_addr <= w_in_win ? {w_row, w_col} : 12'h000;
    end
  end

  always_comb begin
    w_pix = r_rgb1;
    if (r_hblnk1 || r_vblnk1)
      w_pix = 12'h000;
    else if (r_win1 && (bus.rom_rgb != KEY_RGB))
      w_pix = bus.rom_rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount2 <= '0;
      r_vcount2 <= '0;
      r_hsync2  <= 1'b0;
      r_vsync2  <= 1'b0;
      r_hblnk2  <= 1'b0;
      r_vblnk2  <= 1'b0;
      r_rgb2    <= '0;
    end else begin
      r_hcount2 <= r_hcount1;
      r_vcount2 <= r_vcount1;
      r_hsync2  <= r_hsync1;
      r_vsync2  <= r_vsync1;
      r_hblnk2  <= r_hblnk1;
      r_vblnk2  <= r_vblnk1;
      r_rgb2    <= w_pix;
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.hcount_out = r_hcount2;
  assign bus.vcount_out = r_vcount2;
  assign bus.hsync_out  = r_hsync2;
  assign bus.vsync_out  = r_vsync2;
  assign bus.hblnk_out  = r_hblnk2;
  assign bus.vblnk_out  = r_vblnk2;
  assign bus.rgb_out    = r_rgb2;

endmodule
`default_nettype wire

// File: tb/tb_image_draw_ctl.sv
`default_nettype none
// ============================================================================
// tb_image_draw_ctl : directed self-checking bench for image_draw_ctl
// Revision: 1.0
// ============================================================================
module tb_image_draw_ctl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  image_draw_ctl_if bus ();

  image_draw_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic [11:0] bg,
                       input logic [11:0] rom, input logic hb);
    bus.hcount_in = 11'(h);
    bus.vcount_in = 11'(v);
    bus.rgb_in    = bg;
    bus.rom_rgb   = rom;
    bus.hblnk_in  = hb;
    bus.vblnk_in  = 1'b0;
  endtask

  // Hold one pixel for two clocks: address after the first, pixel after the second
  task automatic pixel(input string tag, input int h, input int v,
                       input logic [11:0] bg, input logic [11:0] rom, input logic hb,
                       input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
    drive(h, v, bg, rom, hb);
    tick();
    check({tag, ".addr"}, 32'(bus.rom_addr), 32'(exp_addr));
    tick();
    check({tag, ".rgb"},  32'(bus.rgb_out),  32'(exp_rgb));
    check({tag, ".hcnt"}, 32'(bus.hcount_out), 32'(h));
    check({tag, ".vcnt"}, 32'(bus.vcount_out), 32'(v));
  endtask

  task automatic latch_pos(input int x, input int y);
    bus.xpos     = 12'(x);
    bus.ypos     = 12'(y);
    bus.vblnk_in = 1'b1;
    tick();
    bus.vblnk_in = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n         = 1'b0;
    bus.hsync_in  = 1'b1;
    bus.vsync_in  = 1'b1;
    bus.xpos      = 12'd0;
    bus.ypos      = 12'd0;
    drive(5, 3, 12'h555, 12'h777, 1'b0);
    tick();
    tick();
    check("rst.addr",  32'(bus.rom_addr),   32'h0);
    check("rst.rgb",   32'(bus.rgb_out),    32'h0);
    check("rst.hcnt",  32'(bus.hcount_out), 32'h0);
    check("rst.hsync", 32'(bus.hsync_out),  32'h0);
    check("rst.vsync", 32'(bus.vsync_out),  32'h0);

    // Reset position is (0,0): pixel (5,3) lands at row 3, col 5
    rst_n = 1'b1;
    tick();
    check("rel.addr",  32'(bus.rom_addr),   32'h0C5);
    check("rel.hcnt1", 32'(bus.hcount_out), 32'h0);
    check("rel.rgb1",  32'(bus.rgb_out),    32'h0);
    tick();
    check("rel.hcnt2", 32'(bus.hcount_out), 32'd5);
    check("rel.hsync", 32'(bus.hsync_out),  32'h1);
    check("rel.rgb2",  32'(bus.rgb_out),    32'h777);
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;

    latch_pos(100, 50);
    pixel("topleft",  100,  50, 12'h555, 12'h123, 1'b0, 12'h000, 12'h123);
    pixel("botright", 163, 113, 12'h555, 12'h123, 1'b0, 12'hFFF, 12'h123);
    pixel("rightout", 164, 113, 12'h555, 12'h123, 1'b0, 12'h000, 12'h555);
    pixel("leftout",   99,  50, 12'h555, 12'h123, 1'b0, 12'h000, 12'h555);
    pixel("belowout", 100, 114, 12'h555, 12'h123, 1'b0, 12'h000, 12'h555);
    pixel("key",      110,  60, 12'hABC, 12'hF0F, 1'b0, 12'h28A, 12'hABC);
    pixel("hblank",   110,  60, 12'hABC, 12'h123, 1'b1, 12'h28A, 12'h000);

    // New position requested without a vblank edge: sprite must not move
    bus.xpos = 12'd300;
    pixel("hold.old", 100, 50, 12'h555, 12'h123, 1'b0, 12'h000, 12'h123);
    pixel("hold.new", 300, 50, 12'h555, 12'h123, 1'b0, 12'h000, 12'h555);
    bus.vblnk_in = 1'b1;
    tick();
    bus.vblnk_in = 1'b0;
    tick();
    pixel("move.new", 300, 50, 12'h555, 12'h123, 1'b0, 12'h000, 12'h123);
    pixel("move.old", 100, 50, 12'h555, 12'h123, 1'b0, 12'h000, 12'h555);

    latch_pos(2000, 0);
    pixel("edge.last", 2047, 0, 12'h555, 12'h321, 1'b0, 12'h02F, 12'h321);
    pixel("edge.nowrap",  5, 0, 12'h555, 12'h321, 1'b0, 12'h000, 12'h555);

    latch_pos(4095, 0);
    pixel("far.h2047", 2047, 0, 12'h555, 12'h321, 1'b0, 12'h000, 12'h555);
    pixel("far.h0",       0, 0, 12'h555, 12'h321, 1'b0, 12'h000, 12'h555);

    // Asynchronous reset between clock edges
    latch_pos(100, 50);
    drive(110, 60, 12'h555, 12'h123, 1'b0);
    bus.hsync_in = 1'b1;
    tick();
    tick();
    check("pre.rgb", 32'(bus.rgb_out), 32'h123);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.addr",  32'(bus.rom_addr),   32'h0);
    check("async.rgb",   32'(bus.rgb_out),    32'h0);
    check("async.hcnt",  32'(bus.hcount_out), 32'h0);
    check("async.hsync", 32'(bus.hsync_out),  32'h0);
    tick();
    rst_n = 1'b1;
    bus.hsync_in = 1'b0;
    pixel("post.rst", 5, 3, 12'h555, 12'h0AA, 1'b0, 12'h0C5, 12'h0AA);
    pixel("post.out", 110, 60, 12'h555, 12'h0AA, 1'b0, 12'h000, 12'h555);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_draw_ctl.md
IMAGE_DRAW_CTL -- requirements
Module: image_draw_ctl

Interface
REQ-001 Parameter XPOS_RST, default 12'd0, latched X position after reset.
REQ-002 Parameter YPOS_RST, default 12'd0, latched Y position after reset.
REQ-003 Parameter KEY_RGB, default 12'hF0F, transparent colour in ROM data.
REQ-004 clk  input  1  system/pixel clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 hcount_in, vcount_in  input  11 each  pixel coordinates from upstream timing/draw stage.
REQ-007 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  upstream sync/blank strobes.
REQ-008 rgb_in  input  12  background pixel colour.
REQ-009 xpos, ypos  input  12 each  requested sprite top-left corner, any time.
REQ-010 rom_addr  output  12  ROM address {row[5:0], col[5:0]}, registered.
REQ-011 rom_rgb  input  12  ROM data, valid one clk after rom_addr.
REQ-012 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  output  11/11/1/1/1/1  timing delayed 2 clk.
REQ-013 rgb_out  output  12  composed pixel, aligned with delayed timing.

Function
REQ-014 Position latch: xpos/ypos copied to xpos_l/ypos_l only on cycle where vblnk_in is 1 and was 0 previous cycle (rising edge); held otherwise, so a sprite never tears within a frame.
REQ-015 Stage 1 (registered from inputs at edge k): in_win = (hcount_in >= xpos_l) && (hcount_in < xpos_l+64) && (vcount_in >= ypos_l) && (vcount_in < ypos_l+64), comparisons zero-extended to 13 bits, no wrap.
REQ-016 Stage 1: rom_addr = {(vcount_in-ypos_l)[5:0], (hcount_in-xpos_l)[5:0]} when in_win; 12'h000 otherwise.
REQ-017 Stage 1 also registers rgb_in, in_win and all timing inputs; stage 2 registers them again, giving exactly 2-clk latency on every output.
REQ-018 Stage 2 rgb_out: 12'h000 if hblnk or vblnk (stage-1 copy) is 1; else rom_rgb if in_win (stage-1 copy) is 1 and rom_rgb != KEY_RGB; else rgb_in (stage-1 copy).
REQ-019 Sprite partly off right/bottom edge: only the on-screen part drawn, no wrap to column/row 0.
REQ-020 xpos_l >= 2048 or ypos_l >= 2048: no pixel is in-window; output equals background.
REQ-021 No state other than the latch, two pipeline stages and the previous-vblnk flag.

Reset
REQ-022 While rst_n=0, all outputs 0 (rom_addr, rgb_out, counts, sync, blank), pipeline cleared, xpos_l=XPOS_RST, ypos_l=YPOS_RST, previous-vblnk flag 0.
REQ-023 Reset asserted mid-frame takes effect without waiting for clk; after release, first outputs appear 2 clk after first sampled input; no stale pixel emitted.
REQ-024 After reset, first vblnk rising edge seen is the first rising edge after release (flag starts 0, so vblnk_in=1 at release triggers a latch on the first cycle).

Verification
REQ-025 xpos=100, ypos=50 latched; hcount_in=100, vcount_in=50, no blank -> rom_addr=12'h000 one clk later; rom_rgb=12'h123 -> rgb_out=12'h123 2 clk after input.
REQ-026 hcount_in=163, vcount_in=113 -> rom_addr=12'hFFF; hcount_in=164 -> rom_addr=12'h000 and rgb_out=rgb_in.
REQ-027 rom_rgb=KEY_RGB in window, rgb_in=12'hABC -> rgb_out=12'hABC; hblnk_in=1 in window -> rgb_out=12'h000.
REQ-028 xpos changed 100->300 mid-frame -> drawing stays at 100 until vblnk_in rises, then sprite at 300 in next frame.
REQ-029 xpos=2000 -> columns 2000..2047 drawn (hcount limit), no pixels at hcount 0..15; xpos=4095 -> no sprite pixels.
REQ-030 rst_n pulled low between edges mid-line -> all outputs 0 immediately; after release xpos_l=XPOS_RST, timing outputs track inputs with 2-clk delay.
